hvsync_generator: RTL and testbench
===================================

HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

Interface
REQ-001 SHALL have parameter H_DISPLAY, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FRONT, default 16: horizontal front porch, in clocks.
REQ-003 SHALL have parameter H_SYNC, default 96: hsync pulse width, in clocks.
REQ-004 SHALL have parameter H_BACK, default 48: horizontal back porch, in clocks.
REQ-005 SHALL have parameter V_DISPLAY, default 480: visible lines per frame.
REQ-006 SHALL have parameter V_FRONT, default 10: vertical front porch, in lines.
REQ-007 SHALL have parameter V_SYNC, default 2: vsync pulse width, in lines.
REQ-008 SHALL have parameter V_BACK, default 33: vertical back porch, in lines.
REQ-009 SHALL have parameter SYNC_ACTIVE, default 0: level of hsync/vsync while asserted (0 = active-low, standard VGA).
REQ-010 SHALL have port clk, input, 1 bit: pixel clock (25 MHz for defaults); one clock and all state on its rising edge.
REQ-011 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-012 SHALL have port hsync, output, 1 bit: horizontal sync.
REQ-013 SHALL have port vsync, output, 1 bit: vertical sync.
REQ-014 SHALL have port display_on, output, 1 bit: high while (hpos, vpos) lies in the visible area.
REQ-015 SHALL have port hpos, output, 10 bits: current pixel column counter.
REQ-016 SHALL have port vpos, output, 10 bits: current line counter.

Function
REQ-017 SHALL define H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800) and V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-018 hpos SHALL increment by 1 every clock and wrap from H_TOTAL-1 (799) to 0.
REQ-019 vpos SHALL increment by 1 only on the clock where hpos wraps, and hold otherwise.
REQ-020 vpos SHALL wrap from V_TOTAL-1 (524) to 0 on the same clock that hpos wraps 799 to 0.
REQ-021 hsync SHALL equal SYNC_ACTIVE exactly while H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751), else ~SYNC_ACTIVE.
REQ-022 vsync SHALL equal SYNC_ACTIVE exactly while V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491), else ~SYNC_ACTIVE; the whole line qualifies, independent of hpos.
REQ-023 display_on SHALL be 1 exactly while hpos < H_DISPLAY and vpos < V_DISPLAY.
REQ-024 hsync, vsync and display_on SHALL be registered, computed from the next counter values, so that in every cycle they correspond to the hpos/vpos values presented in that same cycle (zero relative latency, glitch-free).
REQ-025 Counters SHALL never hold a value >= H_TOTAL / V_TOTAL.
REQ-026 A frame SHALL be exactly H_TOTAL*V_TOTAL = 420000 clocks.

Reset
REQ-027 While reset=1, SHALL force hpos=0, vpos=0, display_on=1, hsync=~SYNC_ACTIVE and vsync=~SYNC_ACTIVE, asynchronously.
REQ-028 Reset asserted mid-line or mid-frame SHALL abort the frame; the first clock after release SHALL give hpos=1, vpos=0.
REQ-029 Holding reset at 0 permanently is a supported configuration; the block SHALL free-run from its reset/initial state.

Structure
REQ-030 SHALL place the default timing constants (640/16/96/48, 480/10/2/33) and the derived H_TOTAL/V_TOTAL in a shared video-timing package, reusable by pixel-pipeline blocks.
REQ-031 SHALL be a single module, with no sub-modules; the horizontal and vertical counters are inline logic.

Verification
REQ-032 Release reset, count 800 clocks -> hpos reads 0..799 then 0; vpos steps 0 to 1 exactly on that wrap.
REQ-033 Line 0: hsync low exactly for hpos 656..751 (96 clocks), high elsewhere; display_on high for hpos 0..639 only.
REQ-034 Full frame -> vsync low exactly for vpos 490..491 (1600 clocks); display_on never high for vpos >= 480; vpos wraps 524 to 0 after 420000 clocks.
REQ-035 Assert reset asynchronously at hpos=300, vpos=200 -> outputs immediately hpos=0, vpos=0, display_on=1, hsync=1, vsync=1; after release, count resumes from 1.
REQ-036 Parameter override SYNC_ACTIVE=1 -> hsync/vsync polarity inverted, with identical timing windows.

Source files
------------

// File: rtl/hvsync_generator_pkg.sv
`default_nettype none
// ============================================================================
// Module : hvsync_generator_pkg
// Brief  : Shared video-timing constants (640x480@60 defaults) and helpers.
// Rev    : 1.0  initial release
// ============================================================================
package hvsync_generator_pkg;

    localparam int HV_CNT_W     = 10;

    localparam int HV_H_DISPLAY = 640;
    localparam int HV_H_FRONT   = 16;
    localparam int HV_H_SYNC    = 96;
    localparam int HV_H_BACK    = 48;
    localparam int HV_V_DISPLAY = 480;
    localparam int HV_V_FRONT   = 10;
    localparam int HV_V_SYNC    = 2;
    localparam int HV_V_BACK    = 33;

    localparam int HV_H_TOTAL   = HV_H_DISPLAY + HV_H_FRONT + HV_H_SYNC + HV_H_BACK;
    localparam int HV_V_TOTAL   = HV_V_DISPLAY + HV_V_FRONT + HV_V_SYNC + HV_V_BACK;

    typedef logic [HV_CNT_W-1:0] hv_cnt_t;

    // Half-open window test [lo, hi) on a counter value.
    function automatic logic in_window(hv_cnt_t v, hv_cnt_t lo, hv_cnt_t hi);
        return (v >= lo) && (v < hi);
    endfunction

endpackage : hvsync_generator_pkg
`default_nettype wire

// File: rtl/hvsync_generator_if.sv
`default_nettype none
// ============================================================================
// Module : hvsync_generator_if
// Brief  : Bundle of raster timing outputs (syncs, blanking, position).
// Rev    : 1.0  initial release
// ============================================================================
interface hvsync_generator_if;
    import hvsync_generator_pkg::*;

    logic    hsync;
    logic    vsync;
    logic    display_on;
    hv_cnt_t hpos;
    hv_cnt_t vpos;

    modport master (output hsync, output vsync, output display_on, output hpos, output vpos);
    modport slave  (input  hsync, input  vsync, input  display_on, input  hpos, input  vpos);

endinterface : hvsync_generator_if
`default_nettype wire

// File: rtl/hvsync_generator.sv
`default_nettype none
// ============================================================================
// Module : hvsync_generator
// Brief  : Free-running raster counters with registered sync/blanking outputs.
// Rev    : 1.0  initial release
// ============================================================================
module hvsync_generator
    import hvsync_generator_pkg::*;
#(
    parameter int   H_DISPLAY   = HV_H_DISPLAY,
    parameter int   H_FRONT     = HV_H_FRONT,
    parameter int   H_SYNC      = HV_H_SYNC,
    parameter int   H_BACK      = HV_H_BACK,
    parameter int   V_DISPLAY   = HV_V_DISPLAY,
    parameter int   V_FRONT     = HV_V_FRONT,
    parameter int   V_SYNC      = HV_V_SYNC,
    parameter int   V_BACK      = HV_V_BACK,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  wire logic    clk,
    input  wire logic    reset,
    output logic         hsync,
    output logic         vsync,
    output logic         display_on,
    output hv_cnt_t      hpos,
    output hv_cnt_t      vpos
);

    localparam int      H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int      V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam hv_cnt_t H_LAST   = hv_cnt_t'(H_TOTAL - 1);
    localparam hv_cnt_t V_LAST   = hv_cnt_t'(V_TOTAL - 1);
    localparam hv_cnt_t H_VIS    = hv_cnt_t'(H_DISPLAY);
    localparam hv_cnt_t V_VIS    = hv_cnt_t'(V_DISPLAY);
    localparam hv_cnt_t HS_START = hv_cnt_t'(H_DISPLAY + H_FRONT);
    localparam hv_cnt_t HS_END   = hv_cnt_t'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam hv_cnt_t VS_START = hv_cnt_t'(V_DISPLAY + V_FRONT);
    localparam hv_cnt_t VS_END   = hv_cnt_t'(V_DISPLAY + V_FRONT + V_SYNC);

    hv_cnt_t hpos_q, hpos_d;
    hv_cnt_t vpos_q, vpos_d;
    logic    hsync_q, hsync_d;
    logic    vsync_q, vsync_d;
    logic    display_q, display_d;
    logic    line_end;

    // Wrap on ">=" so an out-of-range power-up value recovers within one line.
    always_comb begin
        line_end  = (hpos_q >= H_LAST);
        hpos_d    = line_end ? '0 : hpos_q + hv_cnt_t'(1);
        vpos_d    = vpos_q;
        if (line_end) begin
            vpos_d = (vpos_q >= V_LAST) ? '0 : vpos_q + hv_cnt_t'(1);
        end
        // Decoded from next-state counters so the registered flags align with hpos/vpos.
        hsync_d   = in_window(hpos_d, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d   = in_window(vpos_d, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        display_d = (hpos_d < H_VIS) && (vpos_d < V_VIS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hpos_q    <= '0;
            vpos_q    <= '0;
            hsync_q   <= ~SYNC_ACTIVE;
            vsync_q   <= ~SYNC_ACTIVE;
            display_q <= 1'b1;
        end else begin
            hpos_q    <= hpos_d;
            vpos_q    <= vpos_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            display_q <= display_d;
        end
    end

    assign hpos       = hpos_q;
    assign vpos       = vpos_q;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign display_on = display_q;

endmodule : hvsync_generator
`default_nettype wire

// File: tb/tb_hvsync_generator.sv
`default_nettype none
// ============================================================================
// Module : tb_hvsync_generator
// Brief  : Randomized-reset bench for hvsync_generator against a position model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_hvsync_generator;
    import hvsync_generator_pkg::*;

    // Small raster for the second instance so whole frames fit in the run.
    localparam int S_HD = 20, S_HF = 4, S_HS = 6, S_HB = 5;
    localparam int S_VD = 12, S_VF = 3, S_VS = 2, S_VB = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   n        = 0;

    always #5 clk = ~clk;

    hvsync_generator_if vid_d ();
    hvsync_generator_if vid_s ();

    hvsync_generator u_dflt (
        .clk        (clk),
        .reset      (reset),
        .hsync      (vid_d.hsync),
        .vsync      (vid_d.vsync),
        .display_on (vid_d.display_on),
        .hpos       (vid_d.hpos),
        .vpos       (vid_d.vpos)
    );

    hvsync_generator #(
        .H_DISPLAY (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
        .V_DISPLAY (S_VD), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
        .SYNC_ACTIVE (1'b1)
    ) u_small (
        .clk        (clk),
        .reset      (reset),
        .hsync      (vid_s.hsync),
        .vsync      (vid_s.vsync),
        .display_on (vid_s.display_on),
        .hpos       (vid_s.hpos),
        .vpos       (vid_s.vpos)
    );

    // Clocks elapsed since reset was last released; the raster position follows from it.
    always @(posedge clk or posedge reset) begin
        if (reset) n <= 0;
        else       n <= n + 1;
    end

    function automatic logic [22:0] pack(logic hs, logic vs, logic de, int h, int v);
        return {hs, vs, de, 10'(h), 10'(v)};
    endfunction

    function automatic logic [22:0] model(int cyc, int hd, int hf, int hs, int hb,
                                          int vd, int vf, int vs, int vb, logic sa);
        int ht, vt, h, v;
        logic s_h, s_v, de;
        ht  = hd + hf + hs + hb;
        vt  = vd + vf + vs + vb;
        h   = cyc % ht;
        v   = (cyc / ht) % vt;
        s_h = (h >= hd + hf && h < hd + hf + hs) ? sa : ~sa;
        s_v = (v >= vd + vf && v < vd + vf + vs) ? sa : ~sa;
        de  = (h < hd) && (v < vd);
        return pack(s_h, s_v, de, h, v);
    endfunction

    function automatic logic [22:0] act_d();
        return {vid_d.hsync, vid_d.vsync, vid_d.display_on, vid_d.hpos, vid_d.vpos};
    endfunction

    function automatic logic [22:0] act_s();
        return {vid_s.hsync, vid_s.vsync, vid_s.display_on, vid_s.hpos, vid_s.vpos};
    endfunction

    task automatic check(string name, logic [22:0] act, logic [22:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s n=%0d act{hs,vs,de}=%b hpos=%0d vpos=%0d exp{hs,vs,de}=%b hpos=%0d vpos=%0d",
                     name, n, act[22:20], act[19:10], act[9:0], exp[22:20], exp[19:10], exp[9:0]);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("model_dflt", act_d(), model(n, HV_H_DISPLAY, HV_H_FRONT, HV_H_SYNC, HV_H_BACK,
                                           HV_V_DISPLAY, HV_V_FRONT, HV_V_SYNC, HV_V_BACK, 1'b0));
        check("model_small", act_s(), model(n, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB, 1'b1));
    end

    task automatic goto(int target);
        int guard = 0;
        while (n < target && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (n != target) begin
            failures++;
            $display("FAIL goto act=%0d exp=%0d", n, target);
        end
    endtask

    task automatic async_reset(int phase);
        @(posedge clk);
        #(phase);
        reset = 1'b1;
        #1;
        check("rst_dflt",  act_d(), pack(1'b1, 1'b1, 1'b1, 0, 0));
        check("rst_small", act_s(), pack(1'b0, 1'b0, 1'b1, 0, 0));
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rel_dflt",  act_d(), pack(1'b1, 1'b1, 1'b1, 1, 0));
        check("rel_small", act_s(), pack(1'b0, 1'b0, 1'b1, 1, 0));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("init_dflt",  act_d(), pack(1'b1, 1'b1, 1'b1, 0, 0));
        check("init_small", act_s(), pack(1'b0, 1'b0, 1'b1, 0, 0));
        release_reset();

        goto(24);   check("s_hs_start",  act_s(), pack(1'b1, 1'b0, 1'b0, 24, 0));
        goto(524);  check("s_pre_vs",    act_s(), pack(1'b0, 1'b0, 1'b0, 34, 14));
        goto(525);  check("s_vs_start",  act_s(), pack(1'b0, 1'b1, 1'b0, 0, 15));
        goto(594);  check("s_vs_last",   act_s(), pack(1'b0, 1'b1, 1'b0, 34, 16));
        goto(595);  check("s_vs_end",    act_s(), pack(1'b0, 1'b0, 1'b0, 0, 17));
        goto(639);  check("d_vis_last",  act_d(), pack(1'b1, 1'b1, 1'b1, 639, 0));
        goto(640);  check("d_blank",     act_d(), pack(1'b1, 1'b1, 1'b0, 640, 0));
        goto(656);  check("d_hs_start",  act_d(), pack(1'b0, 1'b1, 1'b0, 656, 0));
        goto(734);  check("s_frame_end", act_s(), pack(1'b0, 1'b0, 1'b0, 34, 20));
        goto(735);  check("s_frame_wrap",act_s(), pack(1'b0, 1'b0, 1'b1, 0, 0));
        goto(751);  check("d_hs_last",   act_d(), pack(1'b0, 1'b1, 1'b0, 751, 0));
        goto(752);  check("d_hs_end",    act_d(), pack(1'b1, 1'b1, 1'b0, 752, 0));
        goto(799);  check("d_line_end",  act_d(), pack(1'b1, 1'b1, 1'b0, 799, 0));
        goto(800);  check("d_line_wrap", act_d(), pack(1'b1, 1'b1, 1'b1, 0, 1));

        goto(1099);
        @(posedge clk);
        #1;
        check("d_mid_line", act_d(), pack(1'b1, 1'b1, 1'b1, 300, 1));
        reset = 1'b1;
        #1;
        check("rst_mid_dflt",  act_d(), pack(1'b1, 1'b1, 1'b1, 0, 0));
        check("rst_mid_small", act_s(), pack(1'b0, 1'b0, 1'b1, 0, 0));
        release_reset();

        for (int ep = 0; ep < 10; ep++) begin
            repeat ($urandom_range(50, 3000)) @(negedge clk);
            async_reset(int'($urandom_range(1, 3)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_reset();
        end

        repeat (20) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hvsync_generator
`default_nettype wire
